// File: rtl/qsort_n_if.sv
// AXI-Stream input/output bundle for qsort_n.
// sm_tlast exists only when QSORT_N_TLAST_EN is defined.
interface qsort_n_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tready;
    logic                   sm_tready;
    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
`ifdef QSORT_N_TLAST_EN
    logic                   sm_tlast;
`endif

    modport slave (
        input  ss_tvalid, ss_tdata, sm_tready,
        output ss_tready, sm_tvalid, sm_tdata
`ifdef QSORT_N_TLAST_EN
        , output sm_tlast
`endif
    );

    modport master (
        output ss_tvalid, ss_tdata, sm_tready,
        input  ss_tready, sm_tvalid, sm_tdata
`ifdef QSORT_N_TLAST_EN
        , input sm_tlast
`endif
    );
endinterface

// File: rtl/qsort_n.sv
// Frame sorter: loads pN beats, runs pN odd-even transposition phases, streams the result.
// Optional sm_tlast output is enabled by defining QSORT_N_TLAST_EN.
module qsort_n #(
    parameter int pDATA_WIDTH = 32,
    parameter int pN          = 16,
    parameter int pSIGNED     = 0
) (
    input  logic       axis_clk,
    input  logic       axis_rst,
    input  logic       start,
    input  logic       desc,
    output logic       busy,
    output logic       done,
    qsort_n_if.slave   axis
);
    localparam int CW = (pN > 2) ? $clog2(pN) : 1;
    localparam logic [CW-1:0] LAST   = CW'(pN - 1);
    localparam logic [CW-1:0] PENULT = CW'(pN - 2);

    typedef enum logic [2:0] {IDLE, LOAD, SORT, OUT, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          in_cnt;
    logic [CW-1:0]          phase_cnt;
    logic [CW-1:0]          out_cnt;
    logic                   desc_q;
    logic                   ss_tready_q;
    logic                   sm_tvalid_q;
    logic [pDATA_WIDTH-1:0] sm_tdata_q;
    logic                   sm_tlast_q;
    logic [pDATA_WIDTH-1:0] buffer [pN];
    logic [pDATA_WIDTH-1:0] sorted [pN];

    function automatic logic is_greater(input logic [pDATA_WIDTH-1:0] a,
                                        input logic [pDATA_WIDTH-1:0] b);
        if (pSIGNED != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    // One transposition phase: even phases pair (0,1),(2,3)..., odd phases pair (1,2),(3,4)...
    always_comb begin
        for (int i = 0; i < pN; i++)
            sorted[i] = buffer[i];
        for (int i = 0; i < pN - 1; i++) begin
            if ((i % 2 == 1) == phase_cnt[0]) begin
                if (desc_q ? is_greater(buffer[i+1], buffer[i])
                           : is_greater(buffer[i], buffer[i+1])) begin
                    sorted[i]   = buffer[i+1];
                    sorted[i+1] = buffer[i];
                end
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state       <= IDLE;
            in_cnt      <= '0;
            phase_cnt   <= '0;
            out_cnt     <= '0;
            desc_q      <= 1'b0;
            ss_tready_q <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < pN; i++)
                buffer[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        desc_q      <= desc;
                        busy        <= 1'b1;
                        ss_tready_q <= 1'b1;
                        in_cnt      <= '0;
                    end
                end
                LOAD: begin
                    if (axis.ss_tvalid && ss_tready_q) begin
                        buffer[in_cnt] <= axis.ss_tdata;
                        if (in_cnt == LAST) begin
                            state       <= SORT;
                            ss_tready_q <= 1'b0;
                            phase_cnt   <= '0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    buffer <= sorted;
                    // The final phase result is forwarded so the first beat is ready on entry to OUT.
                    if (phase_cnt == LAST) begin
                        state       <= OUT;
                        sm_tvalid_q <= 1'b1;
                        sm_tdata_q  <= sorted[0];
                        sm_tlast_q  <= 1'b0;
                        out_cnt     <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (axis.sm_tready) begin
                        if (out_cnt == LAST) begin
                            state       <= DONE;
                            sm_tvalid_q <= 1'b0;
                            sm_tdata_q  <= '0;
                            sm_tlast_q  <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            out_cnt    <= out_cnt + 1'b1;
                            sm_tdata_q <= buffer[out_cnt + 1'b1];
                            sm_tlast_q <= (out_cnt == PENULT);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    in_cnt    <= '0;
                    phase_cnt <= '0;
                    out_cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axis.ss_tready = ss_tready_q;
    assign axis.sm_tvalid = sm_tvalid_q;
    assign axis.sm_tdata  = sm_tdata_q;
`ifdef QSORT_N_TLAST_EN
    assign axis.sm_tlast  = sm_tlast_q;
`else
    logic unused_tlast;
    assign unused_tlast = sm_tlast_q;
`endif
endmodule

// File: tb/tb_qsort_n.sv
// Bench for qsort_n: an unsigned and a signed instance (pN=8) share one stimulus stream
// and are checked against a sorted-array reference model.
module tb_qsort_n;
    localparam int W = 32;
    localparam int N = 8;

    logic         axis_clk = 1'b0;
    logic         axis_rst;
    logic         start;
    logic         desc;
    logic         busy_u, done_u, busy_s, done_s;
    logic         ss_tvalid;
    logic [W-1:0] ss_tdata;
    logic         sm_tready;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] frame_in [N];
    logic [W-1:0] exp_data [2][N];

    qsort_n_if #(.pDATA_WIDTH(W)) if_u ();
    qsort_n_if #(.pDATA_WIDTH(W)) if_s ();

    assign if_u.ss_tvalid = ss_tvalid;
    assign if_u.ss_tdata  = ss_tdata;
    assign if_u.sm_tready = sm_tready;
    assign if_s.ss_tvalid = ss_tvalid;
    assign if_s.ss_tdata  = ss_tdata;
    assign if_s.sm_tready = sm_tready;

    qsort_n #(.pDATA_WIDTH(W), .pN(N), .pSIGNED(0)) dut_u (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .start    (start),
        .desc     (desc),
        .busy     (busy_u),
        .done     (done_u),
        .axis     (if_u.slave)
    );

    qsort_n #(.pDATA_WIDTH(W), .pN(N), .pSIGNED(1)) dut_s (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .start    (start),
        .desc     (desc),
        .busy     (busy_s),
        .done     (done_s),
        .axis     (if_s.slave)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic get_valid(input int m);
        return (m == 0) ? if_u.sm_tvalid : if_s.sm_tvalid;
    endfunction

    function automatic logic [W-1:0] get_data(input int m);
        return (m == 0) ? if_u.sm_tdata : if_s.sm_tdata;
    endfunction

    function automatic logic get_last(input int m);
`ifdef QSORT_N_TLAST_EN
        return (m == 0) ? if_u.sm_tlast : if_s.sm_tlast;
`else
        return (m < 0);
`endif
    endfunction

    // True when a must be emitted strictly before b for instance m (0 unsigned, 1 signed).
    function automatic bit comes_before(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input int m, input bit d);
        bit lt, gt;
        if (m == 1) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return d ? gt : lt;
    endfunction

    function automatic void build_expected(input bit d);
        logic [W-1:0] tmp;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++)
                exp_data[m][i] = frame_in[i];
            for (int i = 0; i < N - 1; i++)
                for (int j = i + 1; j < N; j++)
                    if (comes_before(exp_data[m][j], exp_data[m][i], m, d)) begin
                        tmp            = exp_data[m][i];
                        exp_data[m][i] = exp_data[m][j];
                        exp_data[m][j] = tmp;
                    end
        end
    endfunction

    task automatic check_quiet(input string tag);
        for (int m = 0; m < 2; m++) begin
            check_output($sformatf("%s_busy%0d", tag, m), (m == 0) ? busy_u : busy_s, 0);
            check_output($sformatf("%s_done%0d", tag, m), (m == 0) ? done_u : done_s, 0);
            check_output($sformatf("%s_ssready%0d", tag, m), (m == 0) ? if_u.ss_tready : if_s.ss_tready, 0);
            check_output($sformatf("%s_smvalid%0d", tag, m), get_valid(m), 0);
            check_output($sformatf("%s_smdata%0d", tag, m), get_data(m), 0);
            check_output($sformatf("%s_smlast%0d", tag, m), get_last(m), 0);
        end
    endtask

    // Called at a falling edge while idle; returns at the falling edge after the last accepted beat.
    task automatic apply_stimulus(input bit d, input bit gaps, input int nbeats);
        int  k   = 0;
        int  cyc = 0;
        bit  acc;
        start = 1'b1;
        desc  = d;
        @(negedge axis_clk);
        start = 1'b0;
        desc  = 1'($urandom_range(0, 1));
        check_output("load_ready_u", if_u.ss_tready, 1);
        check_output("load_ready_s", if_s.ss_tready, 1);
        while (k < nbeats && cyc < 64) begin
            acc = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                ss_tvalid = 1'b0;
                ss_tdata  = $urandom;
            end else begin
                ss_tvalid = 1'b1;
                ss_tdata  = frame_in[k];
                acc       = if_u.ss_tready & if_s.ss_tready;
            end
            @(negedge axis_clk);
            cyc++;
            if (acc) k++;
        end
        ss_tvalid = 1'b0;
        check_output("load_beats", k, nbeats);
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic drain_frame(input int rmode, input bit poke_start);
        int           n = 1;
        int           cyc = 0;
        int           lat [2];
        bit           seen [2];
        int           idx [2];
        bit           held [2];
        logic [W-1:0] held_data [2];
        bit           rdy;
        for (int m = 0; m < 2; m++) begin
            lat[m] = 0; seen[m] = 0; idx[m] = 0; held[m] = 0; held_data[m] = '0;
        end
        sm_tready = 1'b0;
        check_output("ready_drop_u", if_u.ss_tready, 0);
        check_output("ready_drop_s", if_s.ss_tready, 0);
        while (!(seen[0] && seen[1]) && n <= 20) begin
            for (int m = 0; m < 2; m++)
                if (!seen[m] && get_valid(m)) begin
                    seen[m] = 1'b1;
                    lat[m]  = n;
                end
            if (!(seen[0] && seen[1])) begin
                if (poke_start && n == 3) begin
                    start = 1'b1;
                    desc  = ~desc;
                end else begin
                    start = 1'b0;
                end
                @(negedge axis_clk);
                n++;
            end
        end
        start = 1'b0;
        check_output("first_valid_lat_u", lat[0], N + 1);
        check_output("first_valid_lat_s", lat[1], N + 1);

        while ((idx[0] < N || idx[1] < N) && cyc < 200) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sm_tready = rdy;
            for (int m = 0; m < 2; m++) begin
                if (held[m]) begin
                    check_output($sformatf("stall_valid%0d", m), get_valid(m), 1);
                    check_output($sformatf("stall_data%0d", m), get_data(m), held_data[m]);
                end
                held[m] = 1'b0;
                if (get_valid(m)) begin
                    if (rdy) begin
                        if (idx[m] < N) begin
                            check_output($sformatf("beat%0d_data%0d", idx[m], m), get_data(m), exp_data[m][idx[m]]);
`ifdef QSORT_N_TLAST_EN
                            check_output($sformatf("beat%0d_last%0d", idx[m], m), get_last(m), (idx[m] == N - 1));
`endif
                        end else begin
                            check_output($sformatf("extra_beat%0d", m), get_valid(m), 0);
                        end
                        idx[m]++;
                    end else begin
                        held[m]      = 1'b1;
                        held_data[m] = get_data(m);
                    end
                end
            end
            @(negedge axis_clk);
            cyc++;
        end
        sm_tready = 1'b0;
        check_output("beat_count_u", idx[0], N);
        check_output("beat_count_s", idx[1], N);
        check_output("done_pulse_u", done_u, 1);
        check_output("done_pulse_s", done_s, 1);
        check_output("done_valid_u", if_u.sm_tvalid, 0);
        check_output("done_busy_u", busy_u, 1);
        @(negedge axis_clk);
        check_output("done_clear_u", done_u, 0);
        check_output("done_clear_s", done_s, 0);
        check_output("idle_busy_u", busy_u, 0);
        check_output("idle_busy_s", busy_s, 0);
    endtask

    task automatic run_frame(input bit d, input bit gaps, input int rmode, input bit poke_start);
        build_expected(d);
        apply_stimulus(d, gaps, N);
        drain_frame(rmode, poke_start);
    endtask

    initial begin
        axis_rst  = 1'b1;
        start     = 1'b0;
        desc      = 1'b0;
        ss_tvalid = 1'b0;
        ss_tdata  = '0;
        sm_tready = 1'b0;
        repeat (3) @(negedge axis_clk);
        check_quiet("reset");
        axis_rst = 1'b0;
        @(negedge axis_clk);

        // Reference frame ascending, then descending back-to-back.
        frame_in = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd0, 32'd5, 32'd2, 32'd8};
        run_frame(1'b0, 1'b0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 0, 1'b0);

        // Negative value among zeros: signed instance must put -1 first.
        frame_in = '{32'd0, 32'd0, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        run_frame(1'b0, 1'b0, 0, 1'b0);

        // Output backpressure with the 1,0,0,1 ready pattern.
        for (int i = 0; i < N; i++) frame_in[i] = $urandom;
        run_frame(1'b0, 1'b0, 1, 1'b0);

        // Input gaps and a stray start during SORT.
        for (int i = 0; i < N; i++) frame_in[i] = $urandom;
        run_frame(1'b1, 1'b1, 0, 1'b1);

        // Reset mid-load after four beats.
        frame_in = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd0, 32'd5, 32'd2, 32'd8};
        apply_stimulus(1'b0, 1'b0, 4);
        #2 axis_rst = 1'b1;
        #1 check_quiet("midreset");
        @(negedge axis_clk);
        axis_rst  = 1'b0;
        ss_tvalid = 1'b1;
        ss_tdata  = 32'd99;
        repeat (3) begin
            @(negedge axis_clk);
            check_output("post_reset_ready_u", if_u.ss_tready, 0);
            check_output("post_reset_busy_s", busy_s, 0);
        end
        ss_tvalid = 1'b0;
        frame_in = '{32'd4, 32'd4, 32'd4, 32'd1, 32'd1, 32'd1, 32'd6, 32'd6};
        run_frame(1'b0, 1'b0, 0, 1'b0);

        // Randomized frames, alternating wide values and narrow signed values with duplicates.
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < N; i++)
                frame_in[i] = (f % 2 == 1) ? W'($signed($urandom_range(0, 7)) - 3) : $urandom;
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/qsort_n.md
QSORT_N -- requirements
Module: qsort_n

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter pN, default 16, elements per frame; even, 2..64.
REQ-003 SHALL have parameter pSIGNED, default 0; 1 compares two's-complement, 0 compares unsigned.
REQ-004 SHALL have port axis_clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port axis_rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  frame start, honoured only in IDLE.
REQ-007 SHALL have port desc  in  1  sort order, sampled with start: 0 ascending, 1 descending.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port done  out  1  one-cycle pulse after the last output beat.
REQ-010 SHALL have port ss_tvalid  in  1 / ss_tdata  in  pDATA_WIDTH / ss_tready  out  1: AXI-Stream input.
REQ-011 SHALL have port sm_tready  in  1 / sm_tvalid  out  1 / sm_tdata  out  pDATA_WIDTH: AXI-Stream output.
REQ-012 SHALL have port sm_tlast  out  1, present only per REQ-027.

Function
REQ-013 SHALL implement states IDLE, LOAD, SORT, OUT, DONE.
REQ-014 SHALL move IDLE->LOAD on start=1, latching desc; start outside IDLE has no effect.
REQ-015 SHALL drive ss_tready=1 only in LOAD; element k (k-th accepted beat, ss_tvalid&ss_tready) stored at buffer index k.
REQ-016 SHALL move LOAD->SORT on the cycle the pN-th beat is accepted; no further beats accepted.
REQ-017 SHALL sort by odd-even transposition: exactly pN phase cycles; phase p even compares pairs (0,1),(2,3)..., p odd compares (1,2),(3,4)...; all pairs of a phase in one cycle.
REQ-018 SHALL place the lesser element (greater if desc=1) at the lower index of each pair; equal elements unchanged.
REQ-019 SHALL move SORT->OUT after phase pN-1, so first sm_tvalid occurs pN+1 cycles after the last input beat.
REQ-020 SHALL in OUT drive sm_tvalid=1 and sm_tdata=buffer[out_cnt], out_cnt starting at 0, incrementing only on sm_tvalid&sm_tready.
REQ-021 SHALL hold sm_tdata and sm_tvalid stable while sm_tready=0.
REQ-022 SHALL move OUT->DONE on acceptance of beat pN-1; DONE asserts done for one cycle, then ->IDLE.
REQ-023 SHALL allow start in the cycle following DONE (back-to-back frames), buffer overwritten by new frame.
REQ-024 SHALL keep sm_tvalid=0 and done=0 in all states other than OUT and DONE respectively.

Reset
REQ-025 SHALL on axis_rst=1, at any time including mid-frame, immediately force IDLE, counters 0, buffer 0, desc latch 0, ss_tready=0, sm_tvalid=0, sm_tdata=0, done=0, busy=0, sm_tlast=0.
REQ-026 SHALL discard any partial frame on reset; first post-reset action requires a new start.

Configuration
REQ-027 SHALL, when macro QSORT_N_TLAST_EN is defined, provide output sm_tlast, high with sm_tvalid on beat pN-1 only, else 0; when undefined, port sm_tlast absent and no other behaviour changes.

Verification
REQ-028 SHALL cover: pN=8, asc, input 7,3,9,1,0,5,2,8 with sm_tready=1 -> output 0,1,2,3,5,7,8,9, first sm_tvalid 9 cycles after last input, done one cycle after beat 7.
REQ-029 SHALL cover: pN=8, desc=1, same input -> 9,8,7,5,3,2,1,0; pSIGNED=1 input -1,2 among zeros -> -1 first ascending.
REQ-030 SHALL cover: sm_tready toggled 1,0,0,1 repeatedly -> sm_tdata stable during stalls, no beat lost or duplicated, sm_tlast (macro defined) only on 8th beat.
REQ-031 SHALL cover: ss_tvalid gaps between input beats and start pulsed during SORT -> sort unaffected, start ignored.
REQ-032 SHALL cover: axis_rst pulsed after 4 of 8 input beats -> all outputs 0 immediately; next frame 4,4,4,1,1,1,6,6 -> 1,1,1,4,4,4,6,6.
REQ-033 SHALL cover: two frames back-to-back with start in the cycle after done -> both sorted correctly, no data carried over.
